// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory for the MEM stage.
// Serves one MIPS load/store at a time over valid/ready request and
// response channels, with a fixed programmable latency, byte/half/word
// lanes, sign/zero extension and alignment/opcode error reporting.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   req_valid/ready  request handshake (ready only while idle)
//   req_op           MIPS opcode (lb lh lw lbu lhu sb sh sw)
//   req_addr         12-bit byte address, word index req_addr[11:2]
//   req_wdata        store data, byte/half taken from the low bits
//   resp_valid/ready response handshake
//   resp_rdata       extended load data, 0 for stores and errors
//   resp_err         misaligned access or unsupported opcode
//   busy             high whenever not idle, for pipeline stall
module dmem_responder #(
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  req_op,
   input  logic [11:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned ADDR_W = 12;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 1024;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [5:0]          op_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic [DATA_W-1:0]   word_c;
   logic [7:0]          byte_c;
   logic [15:0]         half_c;
   logic [DATA_W-1:0]   rdata_c;
   logic                err_c;
   logic [3:0]          be_c;
   logic [DATA_W-1:0]   wlane_c;
   logic                access_c;

   // Access decode from the captured request: read-side lane select and
   // extension, write-side byte enables with data replicated to all lanes.
   always_comb begin
      word_c  = mem[addr_q[ADDR_W-1:2]];
      rdata_c = '0;
      err_c   = 1'b0;
      be_c    = '0;
      wlane_c = {4{wdata_q[7:0]}};

      case (addr_q[1:0])
         2'd0:    byte_c = word_c[7:0];
         2'd1:    byte_c = word_c[15:8];
         2'd2:    byte_c = word_c[23:16];
         default: byte_c = word_c[31:24];
      endcase
      half_c = addr_q[1] ? word_c[31:16] : word_c[15:0];

      case (op_q)
         OP_LB:  rdata_c = {{24{byte_c[7]}}, byte_c};
         OP_LBU: rdata_c = {24'd0, byte_c};
         OP_LH: begin
            if (addr_q[0]) err_c = 1'b1;
            else           rdata_c = {{16{half_c[15]}}, half_c};
         end
         OP_LHU: begin
            if (addr_q[0]) err_c = 1'b1;
            else           rdata_c = {16'd0, half_c};
         end
         OP_LW: begin
            if (addr_q[1:0] != 2'b00) err_c = 1'b1;
            else                      rdata_c = word_c;
         end
         OP_SB: be_c = 4'b0001 << addr_q[1:0];
         OP_SH: begin
            if (addr_q[0]) err_c = 1'b1;
            else begin
               be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
               wlane_c = {2{wdata_q[15:0]}};
            end
         end
         OP_SW: begin
            if (addr_q[1:0] != 2'b00) err_c = 1'b1;
            else begin
               be_c    = 4'b1111;
               wlane_c = wdata_q;
            end
         end
         default: err_c = 1'b1;
      endcase

      // The access happens exactly on the WAIT->RESP edge.
      access_c = (state == S_WAIT) && (cnt == '0);
   end

   // Storage array; not reset so committed stores survive a reset.
   always_ff @(posedge clk) begin
      if (access_c) begin
         for (int i = 0; i < 4; i++) begin
            if (be_c[i]) mem[addr_q[ADDR_W-1:2]][8*i +: 8] <= wlane_c[8*i +: 8];
         end
      end
   end

   // Control FSM with registered handshake, response and busy outputs.
   // Every latency, including 1, passes through WAIT so that resp_valid
   // always rises exactly LATENCY edges after acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         op_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  op_q      <= req_op;
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  cnt       <= CNT_W'(LATENCY - 1);
                  state     <= S_WAIT;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            S_WAIT: begin
               if (cnt == '0) begin
                  state      <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= rdata_c;
                  resp_err   <= err_c;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  state      <= S_IDLE;
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  busy       <= 1'b0;
               end
            end
            default: begin
               state      <= S_IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder: three instances
// (LATENCY 2, 1, 15), a word-array reference model, per-instance
// expected-response queues drained by monitors on each handshake.
module tb_dmem_responder;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        req_valid  [3];
   logic        req_ready  [3];
   logic [5:0]  req_op     [3];
   logic [11:0] req_addr   [3];
   logic [31:0] req_wdata  [3];
   logic        resp_valid [3];
   logic        resp_ready [3];
   logic [31:0] resp_rdata [3];
   logic        resp_err   [3];
   logic        busy       [3];

   int          errors = 0;
   int          checks = 0;
   exp_t        exp_q [3][$];
   logic [31:0] mem_m [3][1024];
   int          lat_of [3] = '{2, 1, 15};
   logic [5:0]  ops [8] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

   dmem_responder #(.LATENCY(2)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
      .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .busy(busy[0]));

   dmem_responder #(.LATENCY(1)) u_l1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
      .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .busy(busy[1]));

   dmem_responder #(.LATENCY(15)) u_l15 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_op(req_op[2]),
      .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
      .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
      .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]), .busy(busy[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: memory as plain words, lanes picked by shifting.
   function automatic exp_t model_op(input int idx, input logic [5:0] op,
                                     input logic [11:0] a, input logic [31:0] wd);
      exp_t        e;
      int          w;
      int          sh;
      logic [31:0] word;
      logic [7:0]  b;
      logic [15:0] h;
      w    = int'(a[11:2]);
      sh   = 8 * int'(a[1:0]);
      word = mem_m[idx][w];
      b    = 8'(word >> sh);
      h    = 16'(word >> sh);
      e    = '{rdata: 32'd0, err: 1'b0};
      case (op)
         OP_LB:  e.rdata = {{24{b[7]}}, b};
         OP_LBU: e.rdata = {24'd0, b};
         OP_LH:  if (a[0]) e.err = 1'b1; else e.rdata = {{16{h[15]}}, h};
         OP_LHU: if (a[0]) e.err = 1'b1; else e.rdata = {16'd0, h};
         OP_LW:  if (a[1:0] != 2'b00) e.err = 1'b1; else e.rdata = word;
         OP_SB:  mem_m[idx][w] = (word & ~(32'hFF << sh)) | (32'(wd[7:0]) << sh);
         OP_SH:  if (a[0]) e.err = 1'b1;
                 else mem_m[idx][w] = (word & ~(32'hFFFF << sh)) | (32'(wd[15:0]) << sh);
         OP_SW:  if (a[1:0] != 2'b00) e.err = 1'b1; else mem_m[idx][w] = wd;
         default: e.err = 1'b1;
      endcase
      return e;
   endfunction

   // Monitors: pop and compare on every response handshake.
   for (genvar g = 0; g < 3; g++) begin : g_mon
      exp_t e;
      always @(negedge clk) begin
         if (!rst && resp_valid[g] && resp_ready[g]) begin
            if (exp_q[g].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_resp[%0d]: got rdata %h err %b, required no response",
                        g, resp_rdata[g], resp_err[g]);
            end else begin
               e = exp_q[g].pop_front();
               chk($sformatf("rdata[%0d]", g), resp_rdata[g], e.rdata);
               chk($sformatf("err[%0d]", g), 32'(resp_err[g]), 32'(e.err));
            end
         end
      end
   end

   // Issue one request (called #1 after a rising edge with the DUT idle),
   // optionally stall the response for 'hold' cycles.
   task automatic issue(input int idx, input logic [5:0] op, input logic [11:0] a,
                        input logic [31:0] wd, input int hold);
      int          lat;
      logic [31:0] held;
      exp_q[idx].push_back(model_op(idx, op, a, wd));
      req_op[idx]    = op;
      req_addr[idx]  = a;
      req_wdata[idx] = wd;
      req_valid[idx] = 1'b1;
      @(posedge clk); #1;
      req_valid[idx] = 1'b0;
      chk($sformatf("busy_accept[%0d]", idx), 32'(busy[idx]), 32'd1);
      chk($sformatf("req_ready_busy[%0d]", idx), 32'(req_ready[idx]), 32'd0);
      lat = 0;
      while (!resp_valid[idx] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk($sformatf("latency[%0d]", idx), 32'(lat), 32'(lat_of[idx]));
      if (hold > 0) begin
         resp_ready[idx] = 1'b0;
         held = resp_rdata[idx];
         for (int i = 0; i < hold; i++) begin
            req_valid[idx] = (i % 2 == 1);
            @(posedge clk); #1;
            chk($sformatf("hold_valid[%0d]", idx), 32'(resp_valid[idx]), 32'd1);
            chk($sformatf("hold_rdata[%0d]", idx), resp_rdata[idx], held);
            chk($sformatf("hold_req_ready[%0d]", idx), 32'(req_ready[idx]), 32'd0);
         end
         req_valid[idx]  = 1'b0;
         resp_ready[idx] = 1'b1;
      end
      @(posedge clk); #1;
      chk($sformatf("idle_valid[%0d]", idx), 32'(resp_valid[idx]), 32'd0);
      chk($sformatf("idle_req_ready[%0d]", idx), 32'(req_ready[idx]), 32'd1);
      chk($sformatf("idle_busy[%0d]", idx), 32'(busy[idx]), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0]  op;
      logic [11:0] a;
      for (int i = 0; i < 3; i++) begin
         req_valid[i]  = 1'b0;
         req_op[i]     = '0;
         req_addr[i]   = '0;
         req_wdata[i]  = '0;
         resp_ready[i] = 1'b1;
      end
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_req_ready", 32'(req_ready[0]), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
      chk("rst_rdata", resp_rdata[0], 32'd0);
      chk("rst_err", 32'(resp_err[0]), 32'd0);
      chk("rst_busy", 32'(busy[0]), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Seed the low and top address windows used by random traffic.
      for (int w = 0; w < 32; w++) issue(0, OP_SW, 12'(w * 4), $urandom, 0);
      for (int w = 1008; w < 1024; w++) issue(0, OP_SW, 12'(w * 4), $urandom, 0);

      // Directed lane, extension and error cases.
      issue(0, OP_SW, 12'h010, 32'hDEADBEEF, 0);
      issue(0, OP_LW, 12'h010, 32'h0, 0);
      issue(0, OP_SB, 12'h013, 32'h12, 0);
      issue(0, OP_LW, 12'h010, 32'h0, 0);
      issue(0, OP_LB, 12'h013, 32'h0, 0);
      issue(0, OP_LH, 12'h010, 32'h0, 0);
      issue(0, OP_LHU, 12'h010, 32'h0, 0);
      issue(0, OP_LBU, 12'h011, 32'h0, 0);
      issue(0, OP_LW, 12'h012, 32'h0, 0);
      issue(0, OP_SH, 12'h021, 32'hCAFE, 0);
      issue(0, OP_LW, 12'h020, 32'h0, 0);
      issue(0, 6'b000000, 12'h020, 32'h0, 0);
      issue(0, OP_LW, 12'hFFC, 32'h0, 0);

      // Backpressure with ignored request pulses.
      issue(0, OP_LW, 12'h010, 32'h0, 5);
      repeat (4) begin
         @(posedge clk); #1;
         chk("no_extra_resp", 32'(resp_valid[0]), 32'd0);
      end

      // Reset while a store sits in WAIT: the store must be dropped.
      issue(0, OP_LW, 12'h010, 32'h0, 0);
      req_op[0] = OP_SW; req_addr[0] = 12'h030; req_wdata[0] = 32'h11111111;
      req_valid[0] = 1'b1;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_req_ready", 32'(req_ready[0]), 32'd1);
      chk("midrst_resp_valid", 32'(resp_valid[0]), 32'd0);
      chk("midrst_rdata", resp_rdata[0], 32'd0);
      chk("midrst_err", 32'(resp_err[0]), 32'd0);
      chk("midrst_busy", 32'(busy[0]), 32'd0);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      issue(0, OP_LW, 12'h030, 32'h0, 0);

      // Latency sweep and address wrap on the LATENCY=1 and =15 copies.
      for (int idx = 1; idx < 3; idx++) begin
         issue(idx, OP_SW, 12'hFFC, $urandom, 0);
         issue(idx, OP_SW, 12'h000, $urandom, 0);
         issue(idx, OP_LW, 12'hFFC, 32'h0, 0);
         issue(idx, OP_LH, 12'hFFE, 32'h0, 1);
         issue(idx, OP_LBU, 12'h003, 32'h0, 0);
      end

      // Random traffic on the main instance.
      for (int n = 0; n < 120; n++) begin
         int r;
         r  = int'($urandom_range(0, 9));
         op = (r < 8) ? ops[r] : 6'($urandom);
         if ($urandom_range(0, 7) == 0) a = 12'hFC0 | 12'($urandom_range(0, 63));
         else                           a = 12'($urandom_range(0, 127));
         issue(0, op, a, $urandom, ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0);
      end

      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) chk($sformatf("queue_drained[%0d]", i), 32'(exp_q[i].size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
